sc_statemachine_frog_pos2d: RTL and testbench
=============================================

// Module: sc_statemachine_frog_pos2d
// PURPOSE
//  Parametrised 2-D frog position FSM for the Frogger game: tracks frog row/column on a ROWS x COLS grid.
//  Accepts up/down/left/right/restart commands (rising-edge qualified), enforces a move hold-off,
//  detects arrival at the goal row, counts goals and returns the frog to its start cell.
//  Sits between the debounced button logic and the playfield/collision and display blocks.
// PARAMETERS
//  ROWS       8   grid rows; row 0 = start bank, row ROWS-1 = goal row; ROWS >= 2
//  COLS       8   grid columns; COLS >= 2
//  START_COL  3   column the frog occupies after reset, restart or goal; 0 <= START_COL < COLS
//  HOLDOFF    4   clock cycles after an accepted move during which new moves are ignored; 0 = none
//  CNT_W      4   width of goal counter
//  (derived localparams: ROW_W = $clog2(ROWS), COL_W = $clog2(COLS), min 1)
// PORTS
//  SC_STATEMACHINE_FROG_POS2D_CLOCK_50      in   1      system clock, all logic on rising edge
//  SC_STATEMACHINE_FROG_POS2D_RESET         in   1      asynchronous reset, active-high
//  SC_STATEMACHINE_FROG_POS2D_AVANZAR       in   1      move up (row+1), level, synchronous to clock
//  SC_STATEMACHINE_FROG_POS2D_RETROCEDER    in   1      move down (row-1)
//  SC_STATEMACHINE_FROG_POS2D_IZQUIERDA     in   1      move left (col-1)
//  SC_STATEMACHINE_FROG_POS2D_DERECHA       in   1      move right (col+1)
//  SC_STATEMACHINE_FROG_POS2D_INI           in   1      restart: frog to start cell (level-sensitive)
//  SC_STATEMACHINE_FROG_POS2D_ROW           out  ROW_W  current row (registered)
//  SC_STATEMACHINE_FROG_POS2D_COL           out  COL_W  current column (registered)
//  SC_STATEMACHINE_FROG_POS2D_GOAL          out  1      one-cycle pulse: frog reached goal row
//  SC_STATEMACHINE_FROG_POS2D_GOAL_COUNT    out  CNT_W  goals scored, saturating
//  SC_STATEMACHINE_FROG_POS2D_BUSY          out  1      high in HOLD or GOAL state (moves not accepted)
// BEHAVIOUR
//  Reset (async, immediate): ROW=0, COL=START_COL, GOAL=0, GOAL_COUNT=0, BUSY=0, state READY, edge regs=0.
//  Edge detect: rise_x = x & ~x_prev; x_prev registers update every cycle in every state, so a held
//   button produces exactly one move; INI is level, not edge.
//  States: READY, HOLD, GOAL. All outputs registered; a command at edge N is visible after edge N.
//  READY, priority per edge: INI > rise AVANZAR > rise RETROCEDER > rise IZQUIERDA > rise DERECHA;
//   at most one move per edge, lower-priority simultaneous rises are discarded.
//   - INI: ROW=0, COL=START_COL, stay READY (no hold-off).
//   - Blocked move (AVANZAR n/a, RETROCEDER at row 0, IZQUIERDA at col 0, DERECHA at col COLS-1):
//     no position change, stay READY, falls through to no lower-priority command.
//   - Valid move to row < ROWS-1 or horizontal: update ROW/COL; HOLDOFF>0 -> HOLD, counter=HOLDOFF; else READY.
//   - AVANZAR from row ROWS-2: ROW=ROWS-1, GOAL_COUNT+1 (saturates at 2^CNT_W-1), -> GOAL.
//  HOLD: counter decrements each edge; move rises ignored; at counter==1 -> READY. Move accepted at edge N
//   => next accepted move earliest at edge N+HOLDOFF+1. INI in HOLD: go to start cell, -> READY.
//  GOAL: lasts exactly one cycle; GOAL=1 and BUSY=1 during it; at next edge ROW=0, COL=START_COL,
//   GOAL=0, -> READY regardless of inputs (INI has same effect; commands ignored).
//  BUSY = (state != READY), registered with state.
//  Reset asserted mid-HOLD/GOAL: everything returns to reset values at once; counter cleared.
// TESTING  (ROWS=8, COLS=8, START_COL=3, HOLDOFF=4, CNT_W=4 unless stated)
//  1. Reset, 7 one-cycle AVANZAR pulses 6 cycles apart -> ROW 1..7, GOAL=1 one cycle after 7th, COUNT=1, then (0,3).
//  2. AVANZAR held 20 cycles from (0,3) -> exactly one move to (1,3); BUSY high 4 cycles then low.
//  3. DERECHA pulse at edge N, again at N+2, again at N+5 -> col 3->4 at N, ignored at N+2, 4->5 at N+5.
//  4. IZQUIERDA at col 0, DERECHA at col 7, RETROCEDER at row 0 -> no change, BUSY stays 0.
//  5. AVANZAR+DERECHA same edge -> (1,3) only; INI+AVANZAR -> (0,3); 16 goals -> COUNT saturates at 15.
//  6. Async RESET during HOLD at (2,5) -> outputs reset values without a clock edge; next pulse accepted.

Source files
------------

// File: rtl/sc_statemachine_frog_pos2d.sv
// Frog position FSM for Frogger: tracks row/column on a ROWS x COLS grid,
// qualifies move buttons on rising edges, applies a move hold-off and scores goals.
module sc_statemachine_frog_pos2d #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int START_COL = 3,
  parameter int HOLDOFF   = 4,
  parameter int CNT_W     = 4,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             SC_STATEMACHINE_FROG_POS2D_CLOCK_50,
  input  logic             SC_STATEMACHINE_FROG_POS2D_RESET,
  input  logic             SC_STATEMACHINE_FROG_POS2D_AVANZAR,
  input  logic             SC_STATEMACHINE_FROG_POS2D_RETROCEDER,
  input  logic             SC_STATEMACHINE_FROG_POS2D_IZQUIERDA,
  input  logic             SC_STATEMACHINE_FROG_POS2D_DERECHA,
  input  logic             SC_STATEMACHINE_FROG_POS2D_INI,
  output logic [ROW_W-1:0] SC_STATEMACHINE_FROG_POS2D_ROW,
  output logic [COL_W-1:0] SC_STATEMACHINE_FROG_POS2D_COL,
  output logic             SC_STATEMACHINE_FROG_POS2D_GOAL,
  output logic [CNT_W-1:0] SC_STATEMACHINE_FROG_POS2D_GOAL_COUNT,
  output logic             SC_STATEMACHINE_FROG_POS2D_BUSY
);

  localparam int HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_HOLD  = 2'd1,
    S_GOAL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             goal_q, goal_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [3:0]       prev_q, btn, rise;
  logic             moved;

  // Bit order {up, down, left, right} doubles as the priority order.
  assign btn  = {SC_STATEMACHINE_FROG_POS2D_AVANZAR, SC_STATEMACHINE_FROG_POS2D_RETROCEDER,
                 SC_STATEMACHINE_FROG_POS2D_IZQUIERDA, SC_STATEMACHINE_FROG_POS2D_DERECHA};
  assign rise = btn & ~prev_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    goal_d  = 1'b0;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    moved   = 1'b0;
    unique case (state_q)
      S_READY: begin
        if (SC_STATEMACHINE_FROG_POS2D_INI) begin
          row_d = '0;
          col_d = COL_W'(START_COL);
        end else if (rise[3]) begin
          // Only the highest-priority rise is considered, even when it is blocked.
          if (row_q == ROW_W'(ROWS - 2)) begin
            row_d   = ROW_W'(ROWS - 1);
            goal_d  = 1'b1;
            state_d = S_GOAL;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else if (row_q < ROW_W'(ROWS - 2)) begin
            row_d = row_q + ROW_W'(1);
            moved = 1'b1;
          end
        end else if (rise[2]) begin
          if (row_q != '0) begin
            row_d = row_q - ROW_W'(1);
            moved = 1'b1;
          end
        end else if (rise[1]) begin
          if (col_q != '0) begin
            col_d = col_q - COL_W'(1);
            moved = 1'b1;
          end
        end else if (rise[0]) begin
          if (col_q != COL_W'(COLS - 1)) begin
            col_d = col_q + COL_W'(1);
            moved = 1'b1;
          end
        end
        if (moved && (HOLDOFF > 0)) begin
          state_d = S_HOLD;
          hold_d  = HC_W'(HOLDOFF);
        end
      end
      S_HOLD: begin
        if (SC_STATEMACHINE_FROG_POS2D_INI) begin
          row_d   = '0;
          col_d   = COL_W'(START_COL);
          hold_d  = '0;
          state_d = S_READY;
        end else if (hold_q <= HC_W'(1)) begin
          hold_d  = '0;
          state_d = S_READY;
        end else begin
          hold_d = hold_q - HC_W'(1);
        end
      end
      S_GOAL: begin
        row_d   = '0;
        col_d   = COL_W'(START_COL);
        state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
    busy_d = (state_d != S_READY);
  end

  always_ff @(posedge SC_STATEMACHINE_FROG_POS2D_CLOCK_50 or posedge SC_STATEMACHINE_FROG_POS2D_RESET) begin
    if (SC_STATEMACHINE_FROG_POS2D_RESET) begin
      state_q <= S_READY;
      row_q   <= '0;
      col_q   <= COL_W'(START_COL);
      goal_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      goal_q  <= goal_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      prev_q  <= btn;
    end
  end

  assign SC_STATEMACHINE_FROG_POS2D_ROW        = row_q;
  assign SC_STATEMACHINE_FROG_POS2D_COL        = col_q;
  assign SC_STATEMACHINE_FROG_POS2D_GOAL       = goal_q;
  assign SC_STATEMACHINE_FROG_POS2D_GOAL_COUNT = cnt_q;
  assign SC_STATEMACHINE_FROG_POS2D_BUSY       = busy_q;

endmodule

// File: tb/tb_sc_statemachine_frog_pos2d.sv
// Bench for sc_statemachine_frog_pos2d: directed scenarios plus random buttons,
// every cycle compared against a cycle-numbered reference model.
module tb_sc_statemachine_frog_pos2d;

  localparam int ROWS = 8, COLS = 8, START_COL = 3, HOLDOFF = 4, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, ini = 1'b0;
  logic [2:0] row;
  logic [2:0] col;
  logic       goal, busy;
  logic [3:0] cnt;

  sc_statemachine_frog_pos2d #(
    .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .SC_STATEMACHINE_FROG_POS2D_CLOCK_50  (clk),
    .SC_STATEMACHINE_FROG_POS2D_RESET     (rst),
    .SC_STATEMACHINE_FROG_POS2D_AVANZAR   (up),
    .SC_STATEMACHINE_FROG_POS2D_RETROCEDER(dn),
    .SC_STATEMACHINE_FROG_POS2D_IZQUIERDA (lf),
    .SC_STATEMACHINE_FROG_POS2D_DERECHA   (rt),
    .SC_STATEMACHINE_FROG_POS2D_INI       (ini),
    .SC_STATEMACHINE_FROG_POS2D_ROW       (row),
    .SC_STATEMACHINE_FROG_POS2D_COL       (col),
    .SC_STATEMACHINE_FROG_POS2D_GOAL      (goal),
    .SC_STATEMACHINE_FROG_POS2D_GOAL_COUNT(cnt),
    .SC_STATEMACHINE_FROG_POS2D_BUSY      (busy)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  // Reference model: moves are allowed from edge number next_ok onward.
  int m_row, m_col, m_cnt, m_edge, m_next_ok;
  bit m_goal;
  bit p_up, p_dn, p_lf, p_rt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_row = 0; m_col = START_COL; m_cnt = 0; m_goal = 0;
    m_edge = 0; m_next_ok = 0;
    p_up = 0; p_dn = 0; p_lf = 0; p_rt = 0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit l, input bit r, input bit i);
    bit ru, rd, rl, rr;
    ru = u & !p_up; rd = d & !p_dn; rl = l & !p_lf; rr = r & !p_rt;
    p_up = u; p_dn = d; p_lf = l; p_rt = r;
    m_edge++;
    if (m_goal) begin
      m_goal = 0; m_row = 0; m_col = START_COL; m_next_ok = m_edge + 1;
    end else if (i) begin
      m_row = 0; m_col = START_COL; m_next_ok = m_edge + 1;
    end else if (m_edge >= m_next_ok) begin
      if (ru) begin
        if (m_row == ROWS - 2) begin
          m_row = ROWS - 1; m_goal = 1;
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (m_row < ROWS - 2) begin
          m_row++; m_next_ok = m_edge + HOLDOFF + 1;
        end
      end else if (rd) begin
        if (m_row > 0) begin m_row--; m_next_ok = m_edge + HOLDOFF + 1; end
      end else if (rl) begin
        if (m_col > 0) begin m_col--; m_next_ok = m_edge + HOLDOFF + 1; end
      end else if (rr) begin
        if (m_col < COLS - 1) begin m_col++; m_next_ok = m_edge + HOLDOFF + 1; end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic step(input bit u, input bit d, input bit l, input bit r, input bit i);
    up = u; dn = d; lf = l; rt = r; ini = i;
    @(posedge clk);
    model_edge(u, d, l, r, i);
    @(negedge clk);
    chk("row", 32'(row), 32'(m_row));
    chk("col", 32'(col), 32'(m_col));
    chk("goal", 32'(goal), 32'(m_goal));
    chk("count", 32'(cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'((m_goal || (m_edge < m_next_ok - 1)) ? 1 : 0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_row", 32'(row), 0);
    chk("rst_col", 32'(col), START_COL);
    chk("rst_goal", 32'(goal), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int b;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 1: seven spaced up pulses reach the goal row
    for (int p = 1; p <= 7; p++) begin
      step(1, 0, 0, 0, 0);
      chk("t1_row", 32'(row), 32'(p));
      idle(5);
    end
    do_reset();
    for (int p = 1; p <= 6; p++) begin step(1, 0, 0, 0, 0); idle(5); end
    step(1, 0, 0, 0, 0);
    chk("t1_goal", 32'(goal), 1);
    chk("t1_cnt", 32'(cnt), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_home_row", 32'(row), 0);
    chk("t1_home_col", 32'(col), START_COL);

    // 2: held up button moves once; busy lasts HOLDOFF cycles
    b = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, 0);
      if (busy === 1'b1) b++;
    end
    chk("t2_row", 32'(row), 1);
    chk("t2_busy_cycles", 32'(b), HOLDOFF);
    idle(1);

    // 3: right at N, N+2 (ignored), N+5
    step(0, 0, 0, 1, 0); chk("t3_n", 32'(col), 4);
    idle(1);
    step(0, 0, 0, 1, 0); chk("t3_n2", 32'(col), 4);
    idle(2);
    step(0, 0, 0, 1, 0); chk("t3_n5", 32'(col), 5);
    idle(5);

    // 4: blocked moves at the edges of the grid
    do_reset();
    for (int k = 0; k < 3; k++) begin step(0, 0, 1, 0, 0); idle(5); end
    step(0, 0, 1, 0, 0); chk("t4_left_blk", 32'(col), 0); chk("t4_busy_l", 32'(busy), 0);
    for (int k = 0; k < 7; k++) begin step(0, 0, 0, 1, 0); idle(5); end
    step(0, 0, 0, 1, 0); chk("t4_right_blk", 32'(col), 7); chk("t4_busy_r", 32'(busy), 0);
    step(0, 1, 0, 0, 0); chk("t4_down_blk", 32'(row), 0); chk("t4_busy_d", 32'(busy), 0);

    // 5: priority, restart, counter saturation
    do_reset();
    step(1, 0, 0, 1, 0); chk("t5_prio_row", 32'(row), 1); chk("t5_prio_col", 32'(col), START_COL);
    idle(5);
    step(1, 0, 0, 0, 1); chk("t5_ini_row", 32'(row), 0);
    idle(1);
    for (int g = 0; g < 16; g++)
      for (int p = 0; p < 7; p++) begin step(1, 0, 0, 0, 0); idle(5); end
    chk("t5_sat", 32'(cnt), CMAX);

    // 6: asynchronous reset in the middle of a hold-off
    do_reset();
    step(1, 0, 0, 0, 0); idle(4);
    step(1, 0, 0, 0, 0); idle(4);
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); idle(4);
    step(0, 0, 0, 1, 0); idle(1);
    chk("t6_pre_row", 32'(row), 2); chk("t6_pre_col", 32'(col), 5); chk("t6_pre_busy", 32'(busy), 1);
    do_reset();
    step(1, 0, 0, 0, 0); chk("t6_after", 32'(row), 1);
    idle(5);

    // random stimulus
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
